mem_port_arbiter: RTL

Sequential arbiter that shares one main-memory port between the fetch-side instruction refill path and the data-side cache (line refill and line write-back). The arbiter sits between the fetch stage's instruction memory and the memory stage's cache, below both. It grants the port to one requester for a whole burst and drives the beat addresses itself. It also reports which side owns the port, so the hazard unit can hold `CacheStall` correctly.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - burst arbiter sharing one memory port between instruction refill and data cache
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_d,
    output logic              busy
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    // Bits below the burst size are cleared so every burst starts on a burst boundary.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((BURST_LEN * 4) - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [BEAT_W-1:0]   beat_q;
    logic [BEAT_W-1:0]   beat_d;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   base_d;
    // 1 when the most recent grant went to the data side; reset favours data on the first tie.
    logic                last_d_q;
    logic                last_d_d;
    logic                pick_d;
    logic                last_beat;
    logic [ADDR_W-1:0]   beat_addr;

    assign last_beat = (beat_q == LAST_BEAT);
    assign beat_addr = base_q + ADDR_W'({beat_q, 2'b00});

    // State, beat counter, burst base and tie-break history; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            base_q   <= '0;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            base_q   <= base_d;
            last_d_q <= last_d_d;
        end
    end

    // Arbitration in IDLE, beat sequencing in the granted states, and all port outputs.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        last_d_d  = last_d_q;
        pick_d    = 1'b0;
        i_rdata   = '0;
        i_rvalid  = 1'b0;
        i_done    = 1'b0;
        d_rdata   = '0;
        d_rvalid  = 1'b0;
        d_done    = 1'b0;
        d_wready  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        grant_d   = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                // Data wins when alone, or on a tie when instruction side was served last.
                pick_d = d_req && (!i_req || !last_d_q);
                if (pick_d) begin
                    state_d  = d_we ? D_WR : D_RD;
                    base_d   = d_addr & ~LOW_MASK;
                    beat_d   = '0;
                    last_d_d = 1'b1;
                end else if (i_req) begin
                    state_d  = I_RD;
                    base_d   = i_addr & ~LOW_MASK;
                    beat_d   = '0;
                    last_d_d = 1'b0;
                end
            end

            I_RD: begin
                mem_req  = 1'b1;
                busy     = 1'b1;
                mem_addr = beat_addr;
                i_rdata  = mem_rdata;
                if (mem_ready) begin
                    i_rvalid = 1'b1;
                    beat_d   = beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        i_done  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            D_RD: begin
                mem_req  = 1'b1;
                busy     = 1'b1;
                grant_d  = 1'b1;
                mem_addr = beat_addr;
                d_rdata  = mem_rdata;
                if (mem_ready) begin
                    d_rvalid = 1'b1;
                    beat_d   = beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        d_done  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            D_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                busy      = 1'b1;
                grant_d   = 1'b1;
                mem_addr  = beat_addr;
                mem_wdata = d_wdata;
                if (mem_ready) begin
                    d_wready = 1'b1;
                    beat_d   = beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        d_done  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
